// File: rtl/fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer
//
// Read-domain consumer of an asynchronous FIFO. It pops DATA_WIDTH-bit entries,
// packs RATIO consecutive entries into one wide word, and presents the word on
// a valid/ready stream. The first entry goes to lane 0 (little-endian packing).
// The FIFO's one-cycle registered read latency is tracked with a "pend" flag,
// so an entry is never lost or duplicated under backpressure.
//
// Ports:
//   clk_i           read-domain clock, rising edge
//   rst_i           asynchronous, active-high reset
//   fifo_empty_i    FIFO empty flag
//   fifo_rd_data_i  FIFO read data, valid the cycle after a pop
//   fifo_rd_en_o    pop request to the FIFO
//   out_valid_o     packed word available
//   out_ready_i     sink accepts the word
//   out_data_o      packed word (DATA_WIDTH*RATIO bits)
//   busy_o          accumulator non-empty or a read in flight
//   word_cnt_o      number of words accepted by the sink, wraps
//
// Optional feature (macro PACK_FLUSH_EN):
//   flush_i         stop popping and emit the partial word, unused lanes zero
//   out_keep_o      one bit per valid lane, registered with out_data_o
// -----------------------------------------------------------------------------
module fifo_rd_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          fifo_empty_i,
    input  logic [DATA_WIDTH-1:0]         fifo_rd_data_i,
    output logic                          fifo_rd_en_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [DATA_WIDTH*RATIO-1:0]   out_data_o,
    output logic                          busy_o,
    output logic [CNT_WIDTH-1:0]          word_cnt_o
`ifdef PACK_FLUSH_EN
    ,
    input  logic                          flush_i,
    output logic [RATIO-1:0]              out_keep_o
`endif
);

    localparam int                FW      = $clog2(RATIO + 1);
    localparam int                WW      = DATA_WIDTH * RATIO;
    localparam logic [FW-1:0]     RATIO_F = FW'(RATIO);

    typedef enum logic [1:0] {
        ST_IDLE,   // nothing captured, nothing in flight
        ST_FILL,   // partial word or a read in flight
        ST_FULL    // all lanes captured, waiting for the output slot
    } state_e;

    state_e               state_q, state_d;
    logic                 pend_q, pend_d;
    logic [FW-1:0]        fill_q, fill_d;
    logic [WW-1:0]        acc_q, acc_d;
    logic [WW-1:0]        out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic [FW-1:0]        lanes;      // lanes held once this cycle's capture lands
    logic [FW-1:0]        fill_next;  // fill count after a possible transfer
    logic [WW-1:0]        merged;     // accumulator including this cycle's capture
    logic                 slot_free;
    logic                 want_xfer;
    logic                 xfer;
    logic                 rd_en;
`ifdef PACK_FLUSH_EN
    logic                 flush_q, flush_d;
    logic                 flushing;
    logic [RATIO-1:0]     keep_q, keep_d;
`endif

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // through this block leaves a value unassigned and no latch is inferred.
        lanes       = fill_q + FW'(pend_q);
        merged      = acc_q;
        slot_free   = !out_valid_q || out_ready_i;
        want_xfer   = 1'b0;
        xfer        = 1'b0;
        fill_next   = lanes;
        rd_en       = 1'b0;
        pend_d      = 1'b0;
        fill_d      = fill_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !out_ready_i;
        cnt_d       = cnt_q + CNT_WIDTH'(out_valid_q && out_ready_i);
        state_d     = state_q;
`ifdef PACK_FLUSH_EN
        flushing    = flush_q || (flush_i && (lanes != '0));
        flush_d     = 1'b0;
        keep_d      = keep_q;
`endif

        // Data popped last cycle lands in lane fill_q.
        for (int i = 0; i < RATIO; i++) begin
            if (pend_q && (fill_q == FW'(i))) begin
                merged[i*DATA_WIDTH +: DATA_WIDTH] = fifo_rd_data_i;
            end
        end

        // A word completing this cycle is transferred straight away, which
        // gives the two-cycle pop-to-valid latency and one word per RATIO
        // cycles at full rate.
`ifdef PACK_FLUSH_EN
        want_xfer = (lanes == RATIO_F) || (flushing && (lanes != '0));
`else
        want_xfer = (lanes == RATIO_F);
`endif
        xfer      = want_xfer && slot_free;
        fill_next = xfer ? '0 : lanes;

        // Pop only if the lane it will occupy is free after this cycle.
        rd_en = !rst_i && !fifo_empty_i && (fill_next < RATIO_F);
`ifdef PACK_FLUSH_EN
        if (flushing) begin
            rd_en = 1'b0;
        end
        flush_d = flushing && !xfer;
`endif

        pend_d = rd_en;
        fill_d = fill_next;
        acc_d  = xfer ? '0 : merged;

        if (xfer) begin
            out_data_d  = merged;
            out_valid_d = 1'b1;
`ifdef PACK_FLUSH_EN
            for (int i = 0; i < RATIO; i++) begin
                keep_d[i] = (FW'(i) < lanes);
            end
`endif
        end

        if (fill_d == RATIO_F) begin
            state_d = ST_FULL;
        end else if ((fill_d != '0) || pend_d) begin
            state_d = ST_FILL;
        end else begin
            state_d = ST_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            pend_q      <= 1'b0;
            fill_q      <= '0;
            // NOTE: the accumulator is reset as well; flushed words rely on
            // unused lanes being zero, and reset discards any partial word.
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
`ifdef PACK_FLUSH_EN
            flush_q     <= 1'b0;
            keep_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            fill_q      <= fill_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
`ifdef PACK_FLUSH_EN
            flush_q     <= flush_d;
            keep_q      <= keep_d;
`endif
        end
    end

    assign fifo_rd_en_o = rd_en;
    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign word_cnt_o   = cnt_q;
`ifdef PACK_FLUSH_EN
    assign out_keep_o   = keep_q;
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_packer
//
// Self-checking bench for fifo_rd_packer. The bench owns a FIFO model with a
// one-cycle registered read and a reference model that treats the packer as a
// stream: every popped entry is logged, word n is entries [4n..4n+3], and the
// number of lanes in flight is pops minus RATIO times words handed to the
// output slot. A negedge process compares the DUT against that model every
// cycle; directed sequences pin the model with literal expectations.
// -----------------------------------------------------------------------------
module tb_fifo_rd_packer;

    localparam int DW = 8;
    localparam int R  = 4;
    localparam int CW = 16;
    localparam int WW = DW * R;

    logic          clk            = 1'b0;
    logic          rst_i          = 1'b1;
    logic          fifo_empty_i   = 1'b1;
    logic [DW-1:0] fifo_rd_data_i = '0;
    logic          fifo_rd_en_o;
    logic          out_valid_o;
    logic          out_ready_i    = 1'b1;
    logic [WW-1:0] out_data_o;
    logic          busy_o;
    logic [CW-1:0] word_cnt_o;
`ifdef PACK_FLUSH_EN
    logic          flush_i        = 1'b0;
    logic [R-1:0]  out_keep_o;
`endif

    fifo_rd_packer #(.DATA_WIDTH(DW), .RATIO(R), .CNT_WIDTH(CW)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .fifo_empty_i   (fifo_empty_i),
        .fifo_rd_data_i (fifo_rd_data_i),
        .fifo_rd_en_o   (fifo_rd_en_o),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_data_o     (out_data_o),
        .busy_o         (busy_o),
        .word_cnt_o     (word_cnt_o)
`ifdef PACK_FLUSH_EN
        ,
        .flush_i        (flush_i),
        .out_keep_o     (out_keep_o)
`endif
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    bit            chk_en = 1'b0;

    logic [DW-1:0] feed[$];       // entries queued by the stimulus
    int            feed_rd = 0;
    logic [DW-1:0] fifo_q[$];     // FIFO contents
    logic [DW-1:0] popped[$];     // every entry popped since reset
    int            m_xfer  = 0;   // words handed to the output slot
    int            m_acc   = 0;   // words accepted by the sink
    bit            m_valid = 1'b0;

    logic [WW-1:0] acc_data_q[$]; // accepted words as seen on the port
    int            acc_cyc_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int inflight();
        return popped.size() - R * m_xfer;
    endfunction

    function automatic logic [WW-1:0] word_of(input int n);
        logic [WW-1:0] w;
        w = 'x;
        if (n >= 0 && popped.size() >= R * (n + 1)) begin
            for (int i = 0; i < R; i++) w[i*DW +: DW] = popped[R*n + i];
        end
        return w;
    endfunction

    // FIFO model plus reference model update.
    always @(posedge clk) begin : mdl
        bit            xfer;
        logic [DW-1:0] d;
        cyc++;
        if (rst_i) begin
            popped.delete();
            m_xfer  = 0;
            m_acc   = 0;
            m_valid = 1'b0;
        end else begin
            if (out_valid_o && out_ready_i) begin
                acc_data_q.push_back(out_data_o);
                acc_cyc_q.push_back(cyc);
            end
            if (m_valid && out_ready_i) m_acc++;
            xfer    = (inflight() == R) && (!m_valid || out_ready_i);
            m_valid = xfer || (m_valid && !out_ready_i);
            if (xfer) m_xfer++;
            if (fifo_rd_en_o) begin
                check("pop_not_empty", fifo_q.size() != 0, 1'b1);
                if (fifo_q.size() != 0) begin
                    d = fifo_q.pop_front();
                    popped.push_back(d);
                    fifo_rd_data_i <= d;
                end
            end
        end
        while (feed_rd < feed.size()) begin
            fifo_q.push_back(feed[feed_rd]);
            feed_rd++;
        end
        fifo_empty_i <= (fifo_q.size() == 0);
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin : cmp
        bit exp_rd;
        if (chk_en && !rst_i) begin
            exp_rd = !fifo_empty_i &&
                     ((inflight() < R) || ((inflight() == R) && (!m_valid || out_ready_i)));
            check("rd_en", fifo_rd_en_o, exp_rd);
            check("out_valid", out_valid_o, m_valid);
            if (m_valid) check("out_data", out_data_o, word_of(m_xfer - 1));
            check("busy", busy_o, inflight() != 0);
            check("word_cnt", word_cnt_o, CW'(m_acc));
`ifdef PACK_FLUSH_EN
            if (m_valid) check("out_keep", out_keep_o, {R{1'b1}});
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] v);
        feed.push_back(v);
    endtask

    task automatic wait_accepts(input int n, input int budget);
        for (int i = 0; i < budget && acc_data_q.size() < n; i++) tick();
        check("accept_timeout", acc_data_q.size() >= n, 1'b1);
    endtask

    initial begin : stim
        int base;
        // Reset with the FIFO already holding one word; no pop during reset.
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        repeat (3) tick();
        check("rst_valid", out_valid_o, 1'b0);
        check("rst_rd_en", fifo_rd_en_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_cnt", word_cnt_o, 0);
        check("rst_data", out_data_o, 0);
        rst_i  = 1'b0;
        chk_en = 1'b1;
        wait_accepts(1, 20);
        check("t1_word", acc_data_q[0], 32'h44332211);
        tick();
        check("t1_valid_one_cycle", out_valid_o, 1'b0);
        check("t1_cnt", word_cnt_o, 1);

        // Full-rate stream: one word every RATIO cycles.
        base = acc_data_q.size();
        for (int i = 1; i <= 8; i++) push(DW'(i));
        wait_accepts(base + 2, 40);
        check("t2_word0", acc_data_q[base], 32'h04030201);
        check("t2_word1", acc_data_q[base+1], 32'h08070605);
        check("t2_spacing", acc_cyc_q[base+1] - acc_cyc_q[base], R);

        // Sink stall: accumulator fills, pops stop, output holds.
        base = acc_data_q.size();
        out_ready_i = 1'b0;
        for (int i = 1; i <= 12; i++) push(DW'(i));
        repeat (20) tick();
        check("t3_valid", out_valid_o, 1'b1);
        check("t3_hold", out_data_o, 32'h04030201);
        check("t3_no_pop", fifo_rd_en_o, 1'b0);
        check("t3_busy", busy_o, 1'b1);
        out_ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t3_next", out_data_o, 32'h08070605);
        wait_accepts(base + 3, 40);
        check("t3_word2", acc_data_q[base+2], 32'h0C0B0A09);

        // FIFO empties mid-word: partial word held.
        base = acc_data_q.size();
        push(8'h31); push(8'h32); push(8'h33);
        repeat (10) tick();
        check("t4_no_valid", out_valid_o, 1'b0);
        check("t4_busy", busy_o, 1'b1);
        push(8'hAA);
        wait_accepts(base + 1, 20);
        check("t4_word", acc_data_q[base], 32'hAA333231);

        // Reset with a stalled word out and two lanes captured.
        out_ready_i = 1'b0;
        push(8'h41); push(8'h42); push(8'h43); push(8'h44);
        repeat (10) tick();
        push(8'h51); push(8'h52);
        repeat (10) tick();
        check("t5_pre_valid", out_valid_o, 1'b1);
        rst_i = 1'b1;
        #1;
        check("t5_valid", out_valid_o, 1'b0);
        check("t5_data", out_data_o, 0);
        check("t5_busy", busy_o, 1'b0);
        check("t5_cnt", word_cnt_o, 0);
        check("t5_rd_en", fifo_rd_en_o, 1'b0);
        tick();
        rst_i = 1'b0;
        out_ready_i = 1'b1;
        base = acc_data_q.size();
        push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
        wait_accepts(base + 1, 20);
        check("t5_lane0", acc_data_q[base], 32'hC4C3C2C1);
        tick();
        check("t5_cnt_after", word_cnt_o, 1);

        // Randomised traffic and backpressure.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) != 0) push(DW'($urandom));
            if (i % 300 < 40) out_ready_i = 1'b0;
            else              out_ready_i = ($urandom_range(0, 3) != 0);
            tick();
        end

`ifdef PACK_FLUSH_EN
        // Flush of a two-lane partial word.
        chk_en = 1'b0;
        out_ready_i = 1'b1;
        repeat (200) tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        out_ready_i = 1'b0;
        push(8'h5A); push(8'hA5);
        repeat (8) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        repeat (3) tick();
        check("t7_valid", out_valid_o, 1'b1);
        check("t7_data", out_data_o, 32'h0000A55A);
        check("t7_keep", out_keep_o, 4'b0011);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
- Downstream consumer of the asynchronous FIFO read port, running entirely in the read clock domain.
- Pops DATA_WIDTH-bit entries from the FIFO and packs RATIO consecutive entries into one wide word.
- Presents each packed word on a valid/ready output stream.
- Absorbs the FIFO's one-cycle registered read latency so no entry is lost or duplicated under backpressure.

Parameters:
- DATA_WIDTH, 8, width of one FIFO entry.
- RATIO, 4, entries per output word (power of 2, ≥2).
- CNT_WIDTH, 16, width of the packed-word counter.

Ports:
- clk_i  input  1  read-domain clock; all logic on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- fifo_empty_i  input  1  FIFO empty flag (read domain).
- fifo_rd_data_i  input  DATA_WIDTH  FIFO read data; valid the cycle after a pop.
- fifo_rd_en_o  output  1  pop request to FIFO.
- out_valid_o  output  1  packed word available.
- out_ready_i  input  1  sink accepts word.
- out_data_o  output  DATA_WIDTH*RATIO  packed word.
- busy_o  output  1  accumulator non-empty or read in flight.
- word_cnt_o  output  CNT_WIDTH  words accepted by sink, wraps.

Behaviour:
- Reset (async assert, sync release): all outputs 0, fill_cnt=0, pend=0, state=IDLE, accumulator cleared.
- Internal regs:
  - pend: pop issued last cycle.
  - fill_cnt: 0..RATIO, lanes already captured.
  - acc: accumulator.
  - out register.
- Pop rule (combinational): fifo_rd_en_o = !fifo_empty_i && (fill_cnt + pend < RATIO). Never asserted when empty; never over-commits the accumulator.
- Capture: when pend=1, fifo_rd_data_i is written into acc lane fill_cnt (bits [fill_cnt*DATA_WIDTH +: DATA_WIDTH]) and fill_cnt increments. The first entry goes to lane 0 (little-endian packing).
- States:
  - IDLE: fill_cnt=0, pend=0.
  - FILL: 0<fill_cnt<RATIO, or pend=1.
  - FULL: fill_cnt=RATIO.
- Transitions:
  - IDLE→FILL on pop.
  - FILL→FULL on capture of lane RATIO-1.
  - FULL→IDLE or FILL on transfer.
- Transfer: in FULL, when (!out_valid_o || out_ready_i), acc moves to the out register and out_valid_o=1 next cycle. fill_cnt resets to 0 in the same cycle.
  - A pop may issue in that same cycle, because the rule uses the next-state fill_cnt=0.
- Latency: lane RATIO-1 pop at cycle N → out_valid_o at N+2 if the output slot is free.
- Output handshake:
  - out_data_o is stable while out_valid_o && !out_ready_i.
  - out_valid_o deasserts after acceptance unless a new transfer occurs in the same cycle.
  - Back-to-back words at full throughput: one word every RATIO cycles.
- Accounting: word_cnt_o increments on each out_valid_o && out_ready_i, modulo 2^CNT_WIDTH.
- busy_o = (fill_cnt != 0) || pend.
- Boundaries:
  - FIFO empties mid-word: hold the partial word indefinitely, no output.
  - fifo_empty_i deasserts in the same cycle as a transfer: pop allowed.
  - Sink stalled with acc FULL: no pops; FIFO backpressure is via its full flag.
  - rst_i mid-word: partial data discarded, out_valid_o drops immediately.

Optional Feature:
- Macro: PACK_FLUSH_EN.
- With the macro defined, two ports are added:
  - flush_i (input, 1): on a cycle with flush_i=1 and fill_cnt>0, stop popping. After any pending capture, force transfer of the partial word (unused lanes zero).
  - out_keep_o (output, RATIO): one bit per valid lane, registered with out_data_o.
  - flush_i with fill_cnt=0 and pend=0 is ignored.
  - Flush has priority over new pops that cycle.
- Without the macro: ports absent; partial words are only emitted when complete.

Test Plan:
- Reset with FIFO holding 0x11,0x22,0x33,0x44, out_ready_i=1 → out_data_o=0x44332211, out_valid_o high for 1 cycle, word_cnt_o=1.
- Stream 8 entries 0x01..0x08, ready=1 → words 0x04030201 then 0x08070605, one per 4 cycles, no gap beyond pipeline latency.
- Hold out_ready_i=0 after the first word, FIFO has 8 entries → second word fills the acc, fifo_rd_en_o stays 0, out_data_o stable at 0x04030201. Raise ready → 0x08070605 follows next cycle.
- FIFO supplies 3 entries then goes empty → no out_valid_o, busy_o=1. A 4th entry 0xAA arrives → word 0xAA<e2><e1><e0>.
- Assert rst_i with fill_cnt=2 and out_valid_o=1 → all outputs 0 asynchronously. Post-reset words start at lane 0.
- PACK_FLUSH_EN: 2 entries 0x5A,0xA5 then flush_i pulse → out_data_o=0x0000A55A, out_keep_o=4'b0011.
